// File: rtl/rtc_bus_arbiter.sv
// RTC bus arbiter: shares one multiplexed RTC bus among init, write, crono and read requesters.
// Fixed priority with a read anti-starvation override, one transaction per grant, watchdog abort.
module rtc_bus_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 128,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [4*ADDR_W-1:0] addr_in,
  input  logic [4*DATA_W-1:0] data_in,
  input  logic [3:0]          rnw_in,
  input  logic                txn_done,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   data,
  output logic                rnw,
  output logic                txn_start,
  output logic [3:0]          gnt,
  output logic [3:0]          ack,
  output logic                busy,
  output logic                timeout_err
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam int SCW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              rnw_nxt;
  logic              txn_start_nxt;
  logic [3:0]        gnt_nxt;
  logic [3:0]        ack_nxt;
  logic              busy_nxt;
  logic              timeout_err_nxt;
  logic [WCW-1:0]    wait_cnt, wait_nxt;
  logic [SCW-1:0]    starve_cnt, starve_nxt;
  logic [1:0]        win;
  logic              starved;

  assign starved = req[3] && (starve_cnt == SCW'(STARVE_LIM));

  always_comb begin
    win = 2'd3;
    if (req[0])      win = 2'd0;
    else if (starved) win = 2'd3;
    else if (req[1]) win = 2'd1;
    else if (req[2]) win = 2'd2;
  end

  always_comb begin
    state_nxt       = state;
    address_nxt     = address;
    data_nxt        = data;
    rnw_nxt         = rnw;
    txn_start_nxt   = 1'b0;
    gnt_nxt         = gnt;
    ack_nxt         = 4'b0000;
    busy_nxt        = busy;
    timeout_err_nxt = 1'b0;
    wait_nxt        = wait_cnt;
    starve_nxt      = starve_cnt;
    case (state)
      IDLE: begin
        if (!req[3]) starve_nxt = '0;
        if (req != 4'b0000) begin
          gnt_nxt       = 4'b0001 << win;
          address_nxt   = addr_in[int'(win)*ADDR_W +: ADDR_W];
          rnw_nxt       = rnw_in[win];
          data_nxt      = rnw_in[win] ? '0
                                      : data_in[int'(win)*DATA_W +: DATA_W];
          txn_start_nxt = 1'b1;
          busy_nxt      = 1'b1;
          wait_nxt      = '0;
          state_nxt     = WAIT;
          // init grants neither age nor relieve a waiting read
          if (win == 2'd3)
            starve_nxt = '0;
          else if (win != 2'd0 && req[3] && !starved)
            starve_nxt = starve_cnt + SCW'(1);
        end
      end
      WAIT: begin
        wait_nxt = wait_cnt + WCW'(1);
        if (!txn_start && txn_done) begin
          ack_nxt   = gnt;
          gnt_nxt   = 4'b0000;
          data_nxt  = '0;
          state_nxt = DONE;
        end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
          ack_nxt         = gnt;
          gnt_nxt         = 4'b0000;
          data_nxt        = '0;
          timeout_err_nxt = 1'b1;
          state_nxt       = DONE;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      address     <= '0;
      data        <= '0;
      rnw         <= 1'b1;
      txn_start   <= 1'b0;
      gnt         <= 4'b0000;
      ack         <= 4'b0000;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      address     <= address_nxt;
      data        <= data_nxt;
      rnw         <= rnw_nxt;
      txn_start   <= txn_start_nxt;
      gnt         <= gnt_nxt;
      ack         <= ack_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
      wait_cnt    <= wait_nxt;
      starve_cnt  <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: priority, starvation override,
// watchdog, mid-transaction reset and early done rejection.
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [3:0]  rnw_in;
  logic        txn_done;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        rnw;
  logic        txn_start;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  rtc_bus_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .addr_in(addr_in),
    .data_in(data_in), .rnw_in(rnw_in), .txn_done(txn_done),
    .address(address), .data(data), .rnw(rnw), .txn_start(txn_start),
    .gnt(gnt), .ack(ack), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(address), 32'h0);
    chk({tag, "_data"}, 32'(data), 32'h0);
    chk({tag, "_rnw"}, 32'(rnw), 32'h1);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_ack"}, 32'(ack), 32'h0);
    chk({tag, "_start"}, 32'(txn_start), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'h0);
  endtask

  task automatic complete();
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 4'b0; addr_in = '0; data_in = '0;
    rnw_in = 4'b0; txn_done = 1'b0;
    ticks(2);
    reset = 1'b0;
    chk_reset_vals("reset");

    // 1: read request, done 75 cycles after start
    addr_in = 32'h21_00_00_00; data_in = 32'hFF_00_00_00;
    rnw_in = 4'b1000; req = 4'b1000;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h8);
    chk("t1_addr", 32'(address), 32'h21);
    chk("t1_rnw", 32'(rnw), 32'h1);
    chk("t1_data", 32'(data), 32'h0);
    chk("t1_start", 32'(txn_start), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("t1_start_clr", 32'(txn_start), 32'h0);
    ticks(73);
    chk("t1_no_ack_yet", 32'(ack), 32'h0);
    complete();
    chk("t1_ack", 32'(ack), 32'h8);
    chk("t1_gnt_clr", 32'(gnt), 32'h0);
    chk("t1_busy_done", 32'(busy), 32'h1);
    tick();
    chk("t1_ack_clr", 32'(ack), 32'h0);
    chk("t1_busy_low", 32'(busy), 32'h0);

    // 2: write and crono together
    addr_in = 32'h00_22_11_00; data_in = 32'h00_CD_AB_00;
    rnw_in = 4'b0000; req = 4'b0110;
    tick();
    chk("t2_gnt_w", 32'(gnt), 32'h2);
    chk("t2_addr_w", 32'(address), 32'h11);
    chk("t2_data_w", 32'(data), 32'hAB);
    chk("t2_rnw_w", 32'(rnw), 32'h0);
    req = 4'b0100;
    addr_in = 32'h00_22_99_00;
    tick();
    chk("t2_frozen", 32'(address), 32'h11);
    complete();
    chk("t2_ack_w", 32'(ack), 32'h2);
    chk("t2_data_clr", 32'(data), 32'h0);
    tick();
    chk("t2_idle_gap", 32'(gnt), 32'h0);
    tick();
    chk("t2_gnt_c", 32'(gnt), 32'h4);
    chk("t2_addr_c", 32'(address), 32'h22);
    req = 4'b0000;
    tick();
    complete();
    chk("t2_ack_c", 32'(ack), 32'h4);
    tick();

    // 3: starvation override, read wins the 5th arbitration
    rnw_in = 4'b1000; req = 4'b1110;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("t3_gnt_%0d", n), 32'(gnt), (n < 4) ? 32'h2 : 32'h8);
      tick();
      complete();
      tick();
    end
    req = 4'b0000;

    // 4: watchdog
    rnw_in = 4'b0000; req = 4'b0010;
    tick();
    req = 4'b0000;
    ticks(127);
    chk("t4_no_ack_127", 32'(ack), 32'h0);
    tick();
    chk("t4_ack", 32'(ack), 32'h2);
    chk("t4_terr", 32'(timeout_err), 32'h1);
    tick();
    chk("t4_terr_clr", 32'(timeout_err), 32'h0);
    chk("t4_busy_low", 32'(busy), 32'h0);

    // 5: reset during WAIT
    addr_in = 32'h00_00_00_5A; req = 4'b0001;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    ticks(30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("t5_rst");
    complete();
    chk("t5_stray_ack", 32'(ack), 32'h0);
    chk("t5_stray_busy", 32'(busy), 32'h0);

    // 6: done on the start cycle is ignored
    req = 4'b0100;
    tick();
    req = 4'b0000;
    complete();
    chk("t6_ignored_ack", 32'(ack), 32'h0);
    chk("t6_still_gnt", 32'(gnt), 32'h4);
    ticks(3);
    complete();
    chk("t6_ack", 32'(ack), 32'h4);
    tick();

    // 7: done coinciding with the watchdog wins
    req = 4'b0010;
    tick();
    req = 4'b0000;
    ticks(127);
    complete();
    chk("t7_ack", 32'(ack), 32'h2);
    chk("t7_no_terr", 32'(timeout_err), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
